// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into a word store,
// round keys served combinationally by index. Optional macro: AES_KEY_EXPAND_ZEROIZE_EN.
`timescale 1ns/1ps

module aes_key_expand_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    input  logic                zeroize,
`endif
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out,
    output logic                rk_valid
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int CW = 6;

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_expand_iter: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_phase;
    logic [7:0]      r_rcon;
    logic            r_busy;
    logic            r_done;
    logic            r_keys_valid;
    logic [31:0]     r_store [NW];

    logic            w_zeroize;
    logic            w_accept;
    logic            w_write;
    logic            w_last;
    logic            w_rot_case;
    logic            w_sub_case;
    logic [31:0]     w_prev;
    logic [31:0]     w_back;
    logic [31:0]     w_sbox_in;
    logic [31:0]     w_sbox_out;
    logic [31:0]     w_temp;
    logic [31:0]     w_next;
    logic            w_rk_ok;
    logic [CW-1:0]   w_rk_base;

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start && !w_zeroize;
    assign w_write  = (r_state == S_EXPAND) && !w_zeroize;
    assign w_last   = (r_cnt == CW'(NW - 1));

    // r_phase tracks cnt % NK incrementally so NK=6 needs no divider.
    assign w_rot_case = (r_phase == 3'd0);
    assign w_sub_case = (NK == 8) && (r_phase == 3'd4);

    assign w_prev     = r_store[r_cnt - CW'(1)];
    assign w_back     = r_store[r_cnt - CW'(NK)];
    assign w_sbox_in  = w_rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sbox_out = sub_word(w_sbox_in);
    assign w_temp     = w_rot_case ? (w_sbox_out ^ {r_rcon, 24'h0})
                      : w_sub_case ? w_sbox_out
                      : w_prev;
    assign w_next     = w_back ^ w_temp;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_rcon       <= 8'h01;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else if (w_zeroize) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_rcon       <= 8'h01;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt        <= CW'(NK);
                        r_phase      <= '0;
                        r_rcon       <= 8'h01;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
                    if (w_rot_case) r_rcon <= xtime(r_rcon);
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_keys_valid <= 1'b1;
                        r_done       <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) r_store[i] <= '0;
        end else if (w_zeroize) begin
            for (int i = 0; i < NW; i++) r_store[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NK; i++) r_store[i] <= key_in[KEY_BITS-1-32*i -: 32];
        end else if (w_write) begin
            r_store[r_cnt] <= w_next;
        end
    end
`else
    // NOTE: the word store has no reset; contents are only meaningful once keys_valid is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NK; i++) r_store[i] <= key_in[KEY_BITS-1-32*i -: 32];
        end else if (w_write) begin
            r_store[r_cnt] <= w_next;
        end
    end
`endif

    assign w_rk_ok   = (rk_idx <= 4'(NR));
    assign w_rk_base = {rk_idx, 2'b00};

    always_comb begin
        rk_out = '0;
        if (w_rk_ok) begin
            for (int k = 0; k < 4; k++) rk_out[127-32*k -: 32] = r_store[w_rk_base + CW'(k)];
        end
    end

    assign rk_valid   = r_keys_valid && w_rk_ok;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Randomized self-checking bench for aes_key_expand_iter: one instance per key length,
// each compared against a GF(2^8)-arithmetic key-schedule model.
`timescale 1ns/1ps

module tb_aes_key_expand_iter;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [2:0]         start;
    logic [2:0][255:0]  key_in;
    logic [2:0]         busy;
    logic [2:0]         done;
    logic [2:0]         keys_valid;
    logic [2:0][3:0]    rk_idx;
    logic [2:0][127:0]  rk_out;
    logic [2:0]         rk_valid;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    logic [2:0]         zeroize;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ref_sbox [256];
    logic [31:0] exp_w [3][60];

    always #5 clk = ~clk;

    aes_key_expand_iter #(.KEY_BITS(128)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key_in[0][127:0]),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        .zeroize(zeroize[0]),
`endif
        .busy(busy[0]), .done(done[0]), .keys_valid(keys_valid[0]),
        .rk_idx(rk_idx[0]), .rk_out(rk_out[0]), .rk_valid(rk_valid[0])
    );

    aes_key_expand_iter #(.KEY_BITS(192)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key_in[1][191:0]),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        .zeroize(zeroize[1]),
`endif
        .busy(busy[1]), .done(done[1]), .keys_valid(keys_valid[1]),
        .rk_idx(rk_idx[1]), .rk_out(rk_out[1]), .rk_valid(rk_valid[1])
    );

    aes_key_expand_iter #(.KEY_BITS(256)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key_in[2]),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        .zeroize(zeroize[2]),
`endif
        .busy(busy[2]), .done(done[2]), .keys_valid(keys_valid[2]),
        .rk_idx(rk_idx[2]), .rk_out(rk_out[2]), .rk_valid(rk_valid[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---- reference model: plain GF(2^8) arithmetic ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_subw(input logic [31:0] w);
        return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] gpow2(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic build_model(input int d, input logic [255:0] key);
        int nk;
        int nw;
        logic [255:0] sh;
        logic [31:0]  t;
        nk = 4 + 2 * d;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) begin
            sh = key >> (32 * (nk - 1 - i));
            exp_w[d][i] = sh[31:0];
        end
        for (int i = nk; i < nw; i++) begin
            t = exp_w[d][i-1];
            if (i % nk == 0)
                t = ref_subw({t[23:0], t[31:24]}) ^ {gpow2(i / nk - 1), 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = ref_subw(t);
            exp_w[d][i] = exp_w[d][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int d, input int idx);
        return {exp_w[d][4*idx], exp_w[d][4*idx+1], exp_w[d][4*idx+2], exp_w[d][4*idx+3]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---- stimulus helpers; inputs change and outputs are sampled on the falling edge ----
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int d, input logic [255:0] key);
        start[d]  = 1'b1;
        key_in[d] = key;
        step();
        start[d]  = 1'b0;
        key_in[d] = rand256();
    endtask

    task automatic wait_done(input int d, input int inject_at, input logic [255:0] key2, output int lat);
        int cyc;
        cyc = 1;
        lat = 0;
        while (lat == 0 && cyc < 200) begin
            if (done[d]) begin
                lat = cyc;
            end else begin
                if (cyc == inject_at) begin
                    start[d]  = 1'b1;
                    key_in[d] = key2;
                end
                step();
                start[d] = 1'b0;
                cyc++;
            end
        end
        if (lat == 0) lat = cyc;
    endtask

    task automatic check_schedule(input int d, input logic [255:0] key, input string tag);
        int nr;
        nr = 10 + 2 * d;
        build_model(d, key);
        for (int idx = 0; idx < 16; idx++) begin
            rk_idx[d] = 4'(idx);
            #1;
            if (idx <= nr) begin
                check($sformatf("%s_d%0d_rk%0d", tag, d, idx), rk_out[d], exp_rk(d, idx));
                check($sformatf("%s_d%0d_rkvalid%0d", tag, d, idx), rk_valid[d], 1);
            end else begin
                check($sformatf("%s_d%0d_rkzero%0d", tag, d, idx), rk_out[d], 0);
                check($sformatf("%s_d%0d_rkinvalid%0d", tag, d, idx), rk_valid[d], 0);
            end
            step();
        end
    endtask

    task automatic run_and_check(input int d, input logic [255:0] key, input int inject_at,
                                 input logic [255:0] key2, input string tag);
        int lat;
        int nk;
        nk = 4 + 2 * d;
        rk_idx[d] = 4'd0;
        pulse_start(d, key);
        check($sformatf("%s_d%0d_busy", tag, d), busy[d], 1);
        check($sformatf("%s_d%0d_rkvalid_busy", tag, d), rk_valid[d], 0);
        wait_done(d, inject_at, key2, lat);
        check($sformatf("%s_d%0d_latency", tag, d), 128'(lat), 128'(4 * (nk + 7) - nk + 1));
        check($sformatf("%s_d%0d_kv_at_done", tag, d), keys_valid[d], 1);
        check($sformatf("%s_d%0d_busy_at_done", tag, d), busy[d], 0);
        step();
        check($sformatf("%s_d%0d_done_single", tag, d), done[d], 0);
        check_schedule(d, key, tag);
        check($sformatf("%s_d%0d_no_second_done", tag, d), done[d], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k1;
        logic [255:0] k2;
        int           lat;

        for (int i = 0; i < 256; i++) ref_sbox[i] = calc_sbox(8'(i));
        start  = '0;
        key_in = '0;
        rk_idx = '0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        zeroize = '0;
`endif
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_d%0d_busy", d), busy[d], 0);
            check($sformatf("reset_d%0d_done", d), done[d], 0);
            check($sformatf("reset_d%0d_kv", d), keys_valid[d], 0);
            check($sformatf("reset_d%0d_rkvalid", d), rk_valid[d], 0);
        end
        rst_n = 1'b1;
        step();

        // published FIPS-197 vectors
        k1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        run_and_check(0, k1, 0, '0, "tv128");
        rk_idx[0] = 4'd0;  #1 check("tv128_rk0", rk_out[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk_idx[0] = 4'd10; #1 check("tv128_rk10", rk_out[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("tv128_rk10_valid", rk_valid[0], 1);
        step();
        k1 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
        run_and_check(1, k1, 0, '0, "tv192");
        rk_idx[1] = 4'd12; #1 check("tv192_rk12", rk_out[1], 128'ha4970a331a78dc09c418c271e3a41d5d);
        step();
        k1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_and_check(2, k1, 0, '0, "tv256");
        rk_idx[2] = 4'd14; #1 check("tv256_rk14", rk_out[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        step();

        // random keys on every key length
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 3; d++)
                run_and_check(d, rand256(), 0, '0, "rand");

        // start while busy is ignored
        for (int d = 0; d < 3; d++)
            run_and_check(d, rand256(), 10, rand256(), "ignore");

        // start in the done cycle is accepted
        k1 = rand256();
        k2 = rand256();
        pulse_start(0, k1);
        wait_done(0, 0, '0, lat);
        check("backtoback_first_latency", 128'(lat), 128'd41);
        start[0]  = 1'b1;
        key_in[0] = k2;
        step();
        start[0]  = 1'b0;
        check("backtoback_kv_fall", keys_valid[0], 0);
        check("backtoback_busy", busy[0], 1);
        wait_done(0, 0, '0, lat);
        check("backtoback_second_latency", 128'(lat), 128'd41);
        step();
        check_schedule(0, k2, "backtoback");

        // asynchronous reset mid-expansion aborts, then a fresh start rebuilds
        for (int d = 0; d < 3; d += 2) begin
            pulse_start(d, rand256());
            repeat (19) step();
            check($sformatf("midrst_d%0d_busy_before", d), busy[d], 1);
            rst_n = 1'b0;
            #1;
            check($sformatf("midrst_d%0d_busy", d), busy[d], 0);
            check($sformatf("midrst_d%0d_kv", d), keys_valid[d], 0);
            check($sformatf("midrst_d%0d_done", d), done[d], 0);
            step();
            rst_n = 1'b1;
            step();
            step();
            check($sformatf("midrst_d%0d_stays_idle", d), busy[d], 0);
            run_and_check(d, rand256(), 0, '0, "postrst");
        end

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        begin
            logic [31:0] acc;
            run_and_check(0, rand256(), 0, '0, "prezero");
            zeroize[0] = 1'b1;
            start[0]   = 1'b1;
            key_in[0]  = rand256();
            step();
            zeroize[0] = 1'b0;
            start[0]   = 1'b0;
            check("zeroize_kv", keys_valid[0], 0);
            check("zeroize_busy", busy[0], 0);
            check("zeroize_done", done[0], 0);
            acc = '0;
            for (int i = 0; i < 44; i++) acc = acc | u_dut0.r_store[i];
            check("zeroize_store", acc, 0);
            step();
            step();
            check("zeroize_no_start", busy[0], 0);
            run_and_check(0, rand256(), 0, '0, "postzero");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
